// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder
//   Memory-side responder for instruction fetch. Fetch addresses from the PC
//   unit are queued in a small circular FIFO. Each one is then read from a
//   single-port synchronous SRAM after optional wait states. The word is
//   returned on the dataOk_o strobe together with its address. A jump flush
//   drops all queued and in-flight work.
//
//   Optional feature: define FETCH_MISALIGN_CHECK_EN to report fetches with
//   addr[1:0] != 0 as errors. Such fetches skip the SRAM access entirely.
//   Without the macro the low bits are ignored and err_o is always 0.
//
// Parameters
//   DEPTH        queue entries (power of two, >= 2)
//   WAIT_CYCLES  wait states before each SRAM read (0..15)
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   request_i    fetch request strobe; addr_i sampled when request_i && ready_o
//   addr_i       fetch byte address
//   ready_o      queue can accept (combinational: ~full && ~flush_i)
//   flush_i      jump flush
//   mem_en_o     SRAM read enable (one cycle per fetch)
//   mem_addr_o   SRAM word-aligned byte address
//   mem_rdata_i  SRAM read data, valid the cycle after mem_en_o
//   dataOk_o     response strobe
//   rdata_o      returned instruction word
//   raddr_o      address of the returned word
//   err_o        misaligned-fetch error, qualified by dataOk_o
module inst_fetch_responder #(
  parameter int DEPTH       = 4,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        request_i,
  input  logic [31:0] addr_i,
  output logic        ready_o,
  input  logic        flush_i,
  output logic        mem_en_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  output logic        dataOk_o,
  output logic [31:0] rdata_o,
  output logic [31:0] raddr_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  // The counter is loaded on entry to WAIT and then counts down to 0, giving
  // exactly WAIT_CYCLES cycles in WAIT.
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_RESP} state_t;

  state_t        state_reg;
  logic [3:0]    wait_cnt_reg;
  logic [31:0]   cur_addr_reg;
  logic          misalign_reg;
  logic          mem_en_reg;
  logic [31:0]   mem_addr_reg;
  logic          data_ok_reg;
  logic [31:0]   rdata_reg;
  logic [31:0]   raddr_reg;
  logic          err_reg;

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [31:0]   fifo_mem [DEPTH];

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [31:0]   head;
  logic          head_misaligned;

  // Pointers carry one extra wrap bit, so full and empty can be told apart
  // without a separate count.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign ready_o = ~full & ~flush_i;
  assign push    = request_i & ready_o;
  assign pop     = (state_reg == S_IDLE) & ~empty & ~flush_i;
  assign head    = fifo_mem[rd_ptr_reg[AW-1:0]];

`ifdef FETCH_MISALIGN_CHECK_EN
  assign head_misaligned = (head[1:0] != 2'b00);
`else
  assign head_misaligned = 1'b0;
`endif

  assign mem_en_o   = mem_en_reg;
  assign mem_addr_o = mem_addr_reg;
  assign dataOk_o   = data_ok_reg;
  assign rdata_o    = rdata_reg;
  assign raddr_o    = raddr_reg;
  assign err_o      = err_reg;

  // Queue storage has no reset, so it can map onto RAM; validity is tracked
  // by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= addr_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
      cur_addr_reg <= '0;
      misalign_reg <= 1'b0;
      mem_en_reg   <= 1'b0;
      mem_addr_reg <= '0;
      data_ok_reg  <= 1'b0;
      rdata_reg    <= '0;
      raddr_reg    <= '0;
      err_reg      <= 1'b0;
    end else if (flush_i) begin
      // A response that would have been registered at this edge is dropped.
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
      mem_en_reg   <= 1'b0;
      data_ok_reg  <= 1'b0;
    end else begin
      mem_en_reg  <= 1'b0;
      data_ok_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (pop) begin
            cur_addr_reg <= head;
            misalign_reg <= head_misaligned;
            if (head_misaligned) begin
              state_reg <= S_RESP;
            end else if (WAIT_CYCLES > 0) begin
              state_reg    <= S_WAIT;
              wait_cnt_reg <= WAIT_LOAD;
            end else begin
              // mem_en_o is registered, so it is raised on entry to READ.
              state_reg    <= S_READ;
              mem_en_reg   <= 1'b1;
              mem_addr_reg <= {head[31:2], 2'b00};
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg    <= S_READ;
            mem_en_reg   <= 1'b1;
            mem_addr_reg <= {cur_addr_reg[31:2], 2'b00};
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        S_READ: begin
          state_reg <= S_RESP;
        end
        S_RESP: begin
          rdata_reg   <= misalign_reg ? 32'h0 : mem_rdata_i;
          raddr_reg   <= cur_addr_reg;
          err_reg     <= misalign_reg;
          data_ok_reg <= 1'b1;
          state_reg   <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
module tb_inst_fetch_responder;

  logic        clk;
  logic        reset_n;
  logic        request;
  logic [31:0] addr;
  logic        flush;

  // Three instances with different wait-state settings share the inputs;
  // each test checks only the instance it targets.
  logic        ready0, mem_en0, data_ok0, err0;
  logic [31:0] mem_addr0, mem_rdata0, rdata0, raddr0;
  logic        ready4, mem_en4, data_ok4, err4;
  logic [31:0] mem_addr4, mem_rdata4, rdata4, raddr4;
  logic        ready8, mem_en8, data_ok8, err8;
  logic [31:0] mem_addr8, mem_rdata8, rdata8, raddr8;

  int total;
  int bad;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam int   MIS_LAT = 3;
  localparam logic MIS_ERR = 1'b1;
  localparam logic MIS_EN  = 1'b0;
`else
  localparam int   MIS_LAT = 4;
  localparam logic MIS_ERR = 1'b0;
  localparam logic MIS_EN  = 1'b1;
`endif

  inst_fetch_responder #(.DEPTH(4), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .request_i(request), .addr_i(addr),
    .ready_o(ready0), .flush_i(flush), .mem_en_o(mem_en0), .mem_addr_o(mem_addr0),
    .mem_rdata_i(mem_rdata0), .dataOk_o(data_ok0), .rdata_o(rdata0),
    .raddr_o(raddr0), .err_o(err0));

  inst_fetch_responder #(.DEPTH(4), .WAIT_CYCLES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .request_i(request), .addr_i(addr),
    .ready_o(ready4), .flush_i(flush), .mem_en_o(mem_en4), .mem_addr_o(mem_addr4),
    .mem_rdata_i(mem_rdata4), .dataOk_o(data_ok4), .rdata_o(rdata4),
    .raddr_o(raddr4), .err_o(err4));

  inst_fetch_responder #(.DEPTH(4), .WAIT_CYCLES(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .request_i(request), .addr_i(addr),
    .ready_o(ready8), .flush_i(flush), .mem_en_o(mem_en8), .mem_addr_o(mem_addr8),
    .mem_rdata_i(mem_rdata8), .dataOk_o(data_ok8), .rdata_o(rdata8),
    .raddr_o(raddr8), .err_o(err8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // Synchronous SRAM models: data valid the cycle after the enable.
  always @(posedge clk) begin
    mem_rdata0 <= mem_en0 ? sram_word(mem_addr0) : 32'h0;
    mem_rdata4 <= mem_en4 ? sram_word(mem_addr4) : 32'h0;
    mem_rdata8 <= mem_en8 ? sram_word(mem_addr8) : 32'h0;
  end

  task automatic do_reset();
    request = 1'b0;
    flush   = 1'b0;
    addr    = 32'h0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    request = 1'b0;
    flush   = 1'b0;
    addr    = 32'h0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({data_ok0, mem_en0, err0, ready0} !== 4'b0001 || rdata0 !== 32'h0 ||
        raddr0 !== 32'h0 || mem_addr0 !== 32'h0) begin
      bad++;
      $display("FAIL reset_hold ok/en/err/rdy=%b rdata=%h raddr=%h maddr=%h exp 0001/0/0/0",
               {data_ok0, mem_en0, err0, ready0}, rdata0, raddr0, mem_addr0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if ({data_ok0, mem_en0, err0, ready0} !== 4'b0001) begin
        bad++;
        $display("FAIL reset_idle k=%0d ok/en/err/rdy=%b exp 0001", k,
                 {data_ok0, mem_en0, err0, ready0});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      request = (k == 0);
      addr    = 32'h100;
      @(negedge clk);
      total++;
      if (mem_en0 !== (k == 2) || data_ok0 !== (k == 4)) begin
        bad++;
        $display("FAIL single_strobes k=%0d en=%b ok=%b exp en=%b ok=%b", k,
                 mem_en0, data_ok0, (k == 2), (k == 4));
      end
      if (k == 2) begin
        total++;
        if (mem_addr0 !== 32'h100) begin
          bad++;
          $display("FAIL single_maddr got=%h exp=%h", mem_addr0, 32'h100);
        end
      end
      if (k == 4) begin
        total++;
        if (rdata0 !== 32'hDEADBEEF || raddr0 !== 32'h100 || err0 !== 1'b0) begin
          bad++;
          $display("FAIL single_resp rdata=%h raddr=%h err=%b exp deadbeef/100/0",
                   rdata0, raddr0, err0);
        end
      end
      @(posedge clk); #1;
    end
    request = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      request = (k < 3);
      addr    = 32'h100 + 32'(4 * k);
      @(negedge clk);
      total++;
      if (data_ok0 !== (k == 4 || k == 7 || k == 10) ||
          mem_en0 !== (k == 2 || k == 5 || k == 8)) begin
        bad++;
        $display("FAIL b2b_strobes k=%0d ok=%b en=%b", k, data_ok0, mem_en0);
      end
      if (k == 4 || k == 7 || k == 10) begin
        ea = 32'h100 + 32'(4 * ((k - 4) / 3));
        total++;
        if (raddr0 !== ea || rdata0 !== sram_word(ea)) begin
          bad++;
          $display("FAIL b2b_resp k=%0d raddr=%h rdata=%h exp %h/%h", k, raddr0,
                   rdata0, ea, sram_word(ea));
        end
      end
      @(posedge clk); #1;
    end
    request = 1'b0;
  endtask

  task automatic test_full_queue();
    logic        exp_ok;
    logic [31:0] ea;
    do_reset();
    for (int k = 0; k < 66; k++) begin
      request = (k < 6);
      addr    = 32'(4 * k);
      @(negedge clk);
      if (k < 6) begin
        total++;
        if (ready8 !== (k < 5)) begin
          bad++;
          $display("FAIL full_ready k=%0d got=%b exp=%b", k, ready8, (k < 5));
        end
      end
      exp_ok = (k >= 12) && (k <= 56) && (((k - 12) % 11) == 0);
      total++;
      if (data_ok8 !== exp_ok) begin
        bad++;
        $display("FAIL full_dataok k=%0d got=%b exp=%b", k, data_ok8, exp_ok);
      end
      if (exp_ok) begin
        ea = 32'(4 * ((k - 12) / 11));
        total++;
        if (raddr8 !== ea || rdata8 !== sram_word(ea)) begin
          bad++;
          $display("FAIL full_resp k=%0d raddr=%h rdata=%h exp %h/%h", k, raddr8,
                   rdata8, ea, sram_word(ea));
        end
      end
      @(posedge clk); #1;
    end
    request = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 22; k++) begin
      request = (k < 4) || (k == 6);
      flush   = (k == 3);
      addr    = (k == 6) ? 32'h200 : 32'h300 + 32'(4 * k);
      @(negedge clk);
      if (k == 3 || k == 6) begin
        total++;
        if (ready4 !== (k == 6)) begin
          bad++;
          $display("FAIL flush_ready k=%0d got=%b exp=%b", k, ready4, (k == 6));
        end
      end
      total++;
      if (data_ok4 !== (k == 14) || mem_en4 !== (k == 12)) begin
        bad++;
        $display("FAIL flush_strobes k=%0d ok=%b en=%b exp ok=%b en=%b", k,
                 data_ok4, mem_en4, (k == 14), (k == 12));
      end
      if (k == 14) begin
        total++;
        if (raddr4 !== 32'h200 || rdata4 !== sram_word(32'h200)) begin
          bad++;
          $display("FAIL flush_resp raddr=%h rdata=%h exp 200/%h", raddr4, rdata4,
                   sram_word(32'h200));
        end
      end
      @(posedge clk); #1;
    end
    request = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic test_misaligned();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      request = (k == 0);
      addr    = 32'h102;
      @(negedge clk);
      total++;
      if (data_ok0 !== (k == MIS_LAT) || mem_en0 !== (MIS_EN && k == 2)) begin
        bad++;
        $display("FAIL mis_strobes k=%0d ok=%b en=%b", k, data_ok0, mem_en0);
      end
      if (MIS_EN && k == 2) begin
        total++;
        if (mem_addr0 !== 32'h100) begin
          bad++;
          $display("FAIL mis_maddr got=%h exp=100", mem_addr0);
        end
      end
      if (k == MIS_LAT) begin
        total++;
        if (err0 !== MIS_ERR || raddr0 !== 32'h102 ||
            rdata0 !== (MIS_ERR ? 32'h0 : 32'hDEADBEEF)) begin
          bad++;
          $display("FAIL mis_resp err=%b raddr=%h rdata=%h exp err=%b raddr=102",
                   err0, raddr0, rdata0, MIS_ERR);
        end
      end
      @(posedge clk); #1;
    end
    request = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      request = (k == 0);
      addr    = 32'h100;
      if (k < 2) begin
        @(posedge clk); #1;
      end
    end
    // Now early in cycle 2: READ is active.
    total++;
    if (mem_en0 !== 1'b1) begin
      bad++;
      $display("FAIL mid_read_en got=%b exp=1", mem_en0);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({data_ok0, mem_en0, err0} !== 3'b000 || mem_addr0 !== 32'h0 ||
        rdata0 !== 32'h0 || raddr0 !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset_vals ok/en/err=%b maddr=%h rdata=%h raddr=%h exp 0",
               {data_ok0, mem_en0, err0}, mem_addr0, rdata0, raddr0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (data_ok0 !== 1'b0 || mem_en0 !== 1'b0) begin
        bad++;
        $display("FAIL mid_after k=%0d ok=%b en=%b exp 0/0", k, data_ok0, mem_en0);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    request = 1'b0;
    flush   = 1'b0;
    addr    = 32'h0;
    reset_n = 1'b0;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_full_queue();
    test_flush();
    test_misaligned();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
